// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Patterns are active-high {a,b,c,d,e,f,g}, bit 6 = a.
package seven_seg_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h01;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  function automatic logic [6:0] seg_lut(
    input logic [NIBBLE_W-1:0] n
  );
    logic [6:0] p;
    unique case (n)
      4'h0: p = SEG_0;
      4'h1: p = SEG_1;
      4'h2: p = SEG_2;
      4'h3: p = SEG_3;
      4'h4: p = SEG_4;
      4'h5: p = SEG_5;
      4'h6: p = SEG_6;
      4'h7: p = SEG_7;
      4'h8: p = SEG_8;
      4'h9: p = SEG_9;
      4'hA: p = SEG_A;
      4'hB: p = SEG_B;
      4'hC: p = SEG_C;
      4'hD: p = SEG_D;
      4'hE: p = SEG_E;
      4'hF: p = SEG_F;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Nibble to active-high segment pattern, with blanking
// and a dash for 10..15 when hex digits are disabled.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                hex_mode,
  input  logic                blank,
  output logic [6:0]          pattern
);

  logic alpha;

  assign alpha = (nibble > 4'd9);

  always_comb begin
    pattern = SEG_OFF;
    unique case (1'b1)
      blank:
        pattern = SEG_OFF;
      !blank && alpha && !hex_mode:
        pattern = SEG_DASH;
      default:
        pattern = seg_lut(nibble);
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered
// value, one digit per refresh slot with a dead cycle.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]          dp_mask,
  input  logic                           blank_lz,
  output logic [6:0]                     seg,
  output logic                           dp,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           frame_tick
);

  localparam int VW = NIBBLE_W * NUM_DIGITS;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_IDLE =
    {7{SEG_ACTIVE_LOW != 0}};
  localparam logic DP_IDLE = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE =
    {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         stg_val;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic [VW-1:0]         disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic                  tick;
  logic                  wrap;
  logic                  hex_en;
  logic [NIBBLE_W-1:0]   nib;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  zero_run;
  logic                  blank;
  logic [6:0]            pat;
  logic [NUM_DIGITS-1:0] an_sel;

  assign tick   = enable && (cnt == CMAX);
  assign wrap   = tick && (idx == LAST);
  assign hex_en = (HEX_MODE != 0);
  assign an_sel = NUM_DIGITS'(1) << idx;
  assign blank  = blank_lz && lz_sel;

  // lz_sel: every nibble from the MSD down to idx is zero
  always_comb begin
    nib      = '0;
    dp_sel   = 1'b0;
    lz_sel   = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run &&
        (disp_val[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (idx == IW'(i)) begin
        nib    = disp_val[i*NIBBLE_W +: NIBBLE_W];
        dp_sel = disp_dp[i];
        lz_sel = zero_run && (i != 0);
      end
    end
  end

  seven_seg_decoder u_dec (
    .nibble   (nib),
    .hex_mode (hex_en),
    .blank    (blank),
    .pattern  (pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_val    <= '0;
      stg_dp     <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        stg_val <= value;
        stg_dp  <= dp_mask;
      end
      if (wrap) begin
        disp_val <= load ? value : stg_val;
        disp_dp  <= load ? dp_mask : stg_dp;
      end
      frame_tick <= wrap;
    end
  end

  // tick edge is the anti-ghosting dead cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
      an  <= AN_IDLE;
    end else if (!enable || tick) begin
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
      an  <= AN_IDLE;
    end else begin
      seg <= pat ^ SEG_IDLE;
      dp  <= dp_sel ^ DP_IDLE;
      an  <= an_sel ^ AN_IDLE;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver, checking a
// HEX_MODE=0 and a HEX_MODE=1 instance against a frame model.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic       ft0, ft1;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_dec0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0),
    .an(an0), .frame_tick(ft0)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_hex1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg1), .dp(dp1),
    .an(an1), .frame_tick(ft1)
  );

  logic [6:0] tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // model: p = enabled edges since reset; slot = p/4, digit = slot%4
  int          p;
  logic [15:0] stg, disp;
  logic [3:0]  stg_dp, disp_dp;
  logic [6:0]  e_seg0, e_seg1;
  logic        e_dp, e_ft;
  logic [3:0]  e_an;

  function automatic logic [6:0] pat(
    input logic [3:0] n, input bit hex, input bit blank
  );
    if (blank) return 7'h00;
    if (n > 9 && !hex) return 7'h01;
    return tab[n];
  endfunction

  task automatic chk(
    input string tag, input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t",
        tag, got, exp, $time);
    end
  endtask

  task automatic set_dark();
    e_seg0 = 7'h7F;
    e_seg1 = 7'h7F;
    e_dp   = 1'b1;
    e_an   = 4'hF;
  endtask

  task automatic model_reset();
    p = 0;
    stg = '0; stg_dp = '0;
    disp = '0; disp_dp = '0;
    e_ft = 1'b0;
    set_dark();
  endtask

  task automatic model_edge();
    bit wrap, dead, blank;
    int d;
    logic [3:0] n;
    wrap = enable && (p % 16 == 15);
    dead = enable && (p % 4 == 3);
    if (wrap) begin
      disp    = load ? value : stg;
      disp_dp = load ? dp_mask : stg_dp;
    end
    if (load) begin
      stg    = value;
      stg_dp = dp_mask;
    end
    e_ft = wrap;
    if (enable) p++;
    if (!enable || dead) begin
      set_dark();
    end else begin
      d = (p / 4) % 4;
      n = disp[4*d +: 4];
      blank = blank_lz && d != 0 && (disp >> (4*d)) == 0;
      e_seg0 = ~pat(n, 1'b0, blank);
      e_seg1 = ~pat(n, 1'b1, blank);
      e_dp   = ~disp_dp[d];
      e_an   = ~(4'b0001 << d);
    end
  endtask

  task automatic compare();
    chk("seg_h0", 16'(seg0), 16'(e_seg0));
    chk("seg_h1", 16'(seg1), 16'(e_seg1));
    chk("dp_h0", 16'(dp0), 16'(e_dp));
    chk("dp_h1", 16'(dp1), 16'(e_dp));
    chk("an_h0", 16'(an0), 16'(e_an));
    chk("an_h1", 16'(an1), 16'(e_an));
    chk("ft_h0", 16'(ft0), 16'(e_ft));
    chk("ft_h1", 16'(ft1), 16'(e_ft));
  endtask

  task automatic step(
    input logic en, input logic ld, input logic [15:0] v,
    input logic [3:0] dpm, input logic blz
  );
    enable = en; load = ld; value = v;
    dp_mask = dpm; blank_lz = blz;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ?
        4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic idle_until(input int phase16, input logic blz);
    for (int k = 0; k < 64 && (p % 16) != phase16; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, blz);
  endtask

  initial begin
    #2;
    do_reset();

    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    step(1'b1, 1'b1, 16'h0050, 4'b0010, 1'b1);
    for (int k = 0; k < 36; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    step(1'b1, 1'b1, 16'hABCD, 4'b1001, 1'b0);
    for (int k = 0; k < 36; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    idle_until(15, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h5678, 4'hF, 1'b0);
    for (int k = 0; k < 36; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    idle_until(9, 1'b0);
    for (int k = 0; k < 7; k++)
      step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    step(1'b1, 1'b1, 16'h8888, 4'hF, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    do_reset();
    for (int k = 0; k < 40; k++)
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    for (int k = 0; k < 2500; k++)
      step(
        $urandom_range(0, 15) != 0,
        $urandom_range(0, 9) == 0,
        rnd_val(),
        4'($urandom_range(0, 15)),
        (k / 200) % 2 == 0
      );

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
